// File: rtl/victim_cache_param_if.sv
// victim_cache_param_if: load/write bus between the L1 side and the victim cache
interface victim_cache_param_if #(
    parameter int BLOCK_BITS  = 512,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 6,
    parameter int TAG_BITS    = 44
);
    logic [INDEX_BITS+OFFSET_BITS-1:0] addr_in;
    logic                              rd_en;
    logic                              tlb_miss;
    logic [TAG_BITS-1:0]               phys_tag_ret;
    logic                              write_en;
    logic [TAG_BITS-1:0]               wr_tag;
    logic [BLOCK_BITS-1:0]             data_in;
    logic                              rd_valid;
    logic                              is_found;
    logic [7:0]                        byte_out;
    logic [BLOCK_BITS-1:0]             data_out;

    modport master (
        output addr_in, rd_en, tlb_miss, phys_tag_ret, write_en, wr_tag, data_in,
        input  rd_valid, is_found, byte_out, data_out
    );

    modport slave (
        input  addr_in, rd_en, tlb_miss, phys_tag_ret, write_en, wr_tag, data_in,
        output rd_valid, is_found, byte_out, data_out
    );
endinterface

// File: rtl/victim_cache_param.sv
// victim_cache_param: fully-associative victim cache, true-LRU, two-stage loads, optional exclusive hits
module victim_cache_param #(
    parameter int NUM_ENTRIES = 8,
    parameter int BLOCK_BITS  = 512,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 6,
    parameter int TAG_BITS    = 44,
    parameter bit EXCLUSIVE   = 1
) (
    input logic clk,
    input logic reset,
    victim_cache_param_if.slave bus
);
    localparam int AW = $clog2(NUM_ENTRIES);
    localparam logic [AW-1:0] LRU = AW'(NUM_ENTRIES - 1);
    localparam logic [AW-1:0] ONE = AW'(1);

    logic [BLOCK_BITS-1:0]  blk   [NUM_ENTRIES];
    logic [TAG_BITS-1:0]    tag   [NUM_ENTRIES];
    logic [INDEX_BITS-1:0]  idx   [NUM_ENTRIES];
    logic [AW-1:0]          age   [NUM_ENTRIES];
    logic [AW-1:0]          age_h [NUM_ENTRIES];
    logic [AW-1:0]          age_n [NUM_ENTRIES];
    logic [7:0]             s_byte[NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] vld, vld_h, vld_n;

    logic                   s_vld;
    logic [INDEX_BITS-1:0]  s_idx;
    logic [OFFSET_BITS-1:0] off;
    logic [INDEX_BITS-1:0]  a_idx;
    logic                   found;
    logic [AW-1:0]          hi, hit_age;
    logic                   have_match, have_free;
    logic [AW-1:0]          m_t, f_t, l_t, tgt, tgt_age;

    assign {a_idx, off} = bus.addr_in;

    // Stage 2: associative compare of the piped index and late physical tag
    always_comb begin
        found = 1'b0;
        hi    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (s_vld && vld[i] && tag[i] == bus.phys_tag_ret && idx[i] == s_idx) begin
                found = 1'b1;
                hi    = AW'(i);
            end
    end

    assign bus.rd_valid = s_vld;
    assign bus.is_found = found;
    assign bus.byte_out = found ? s_byte[hi] : 8'h00;
    assign bus.data_out = found ? blk[hi] : '0;

    // Hit update: exclusive frees the entry and sinks it to LRU, otherwise it rises to MRU
    always_comb begin
        hit_age = age[hi];
        vld_h   = vld;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            age_h[i] = age[i];
            if (found) begin
                if (AW'(i) == hi)
                    age_h[i] = EXCLUSIVE ? LRU : '0;
                else if (EXCLUSIVE && age[i] > hit_age)
                    age_h[i] = age[i] - ONE;
                else if (!EXCLUSIVE && age[i] < hit_age)
                    age_h[i] = age[i] + ONE;
            end
        end
        if (found && EXCLUSIVE)
            vld_h[hi] = 1'b0;
    end

    // Write placement on the post-hit state: duplicate tag, else lowest free, else LRU; target becomes MRU
    always_comb begin
        have_match = 1'b0;
        have_free  = 1'b0;
        m_t        = '0;
        f_t        = '0;
        l_t        = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (vld_h[i] && tag[i] == bus.wr_tag && idx[i] == a_idx) begin
                have_match = 1'b1;
                m_t        = AW'(i);
            end
            if (!vld_h[i]) begin
                have_free = 1'b1;
                f_t       = AW'(i);
            end
            if (age_h[i] == LRU)
                l_t = AW'(i);
        end
        tgt     = have_match ? m_t : have_free ? f_t : l_t;
        tgt_age = age_h[tgt];
        vld_n   = vld_h;
        for (int i = 0; i < NUM_ENTRIES; i++)
            age_n[i] = !bus.write_en ? age_h[i] :
                       AW'(i) == tgt ? '0 :
                       age_h[i] < tgt_age ? age_h[i] + ONE : age_h[i];
        if (bus.write_en)
            vld_n[tgt] = 1'b1;
    end

    // State: stage-1 capture, replacement ages, valid bits and block storage
    always_ff @(posedge clk) begin
        if (reset) begin
            s_vld <= 1'b0;
            s_idx <= '0;
            vld   <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                s_byte[i] <= '0;
                blk[i]    <= '0;
                tag[i]    <= '0;
                idx[i]    <= '0;
                age[i]    <= AW'(i);
            end
        end else begin
            s_vld <= bus.rd_en && !bus.tlb_miss && !bus.write_en;
            vld   <= vld_n;
            if (bus.rd_en)
                s_idx <= a_idx;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age[i] <= age_n[i];
                if (bus.rd_en)
                    s_byte[i] <= blk[i][{off, 3'b000} +: 8];
                if (bus.write_en && AW'(i) == tgt) begin
                    blk[i] <= bus.data_in;
                    tag[i] <= bus.wr_tag;
                    idx[i] <= a_idx;
                end
            end
        end
    end
endmodule
